// File: rtl/rxparity.sv
// Serial frame receiver: start, 8 data bits LSB first, parity, stop.
// Parity mode is captured at the start bit and checked at the stop bit.
module rxparity (
  input  logic       i_Pclk,
  input  logic       i_Rst,
  input  logic       i_BitEn,
  input  logic       i_Rx,
  input  logic [1:0] i_Parity,
  output logic [7:0] o_Data,
  output logic       o_Valid,
  output logic       o_ParityErr,
  output logic       o_FrameErr,
  output logic       o_Busy
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic [1:0] mode;
  logic       par_bit;
  logic       ones_odd;
  logic       par_err;

  assign ones_odd = ^shift ^ par_bit;
  assign o_Busy   = (state != IDLE);

  always_comb begin
    par_err = 1'b0;
    unique case (mode)
      2'b01:   par_err = ones_odd;
      2'b10:   par_err = ~ones_odd;
      default: par_err = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (i_BitEn) begin
      unique case (state)
        IDLE:   if (!i_Rx) state_nxt = DATA;
        DATA:   if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY: state_nxt = STOP;
        STOP:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Pclk or posedge i_Rst) begin
    if (i_Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_Pclk or posedge i_Rst) begin
    if (i_Rst) begin
      bit_cnt     <= 3'd0;
      shift       <= 8'h00;
      mode        <= 2'b00;
      par_bit     <= 1'b0;
      o_Data      <= 8'h00;
      o_Valid     <= 1'b0;
      o_ParityErr <= 1'b0;
      o_FrameErr  <= 1'b0;
    end else begin
      o_Valid <= 1'b0;
      if (i_BitEn) begin
        unique case (state)
          IDLE: begin
            if (!i_Rx) begin
              bit_cnt <= 3'd0;
              mode    <= i_Parity;
            end
          end
          DATA: begin
            shift   <= {i_Rx, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: par_bit <= i_Rx;
          STOP: begin
            o_Data      <= shift;
            o_Valid     <= 1'b1;
            o_ParityErr <= par_err;
            o_FrameErr  <= ~i_Rx;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rxparity.sv
// Scoreboard bench for rxparity: frames are queued as they are sent
// and matched against each o_Valid pulse.
module tb_rxparity;

  logic       clk;
  logic       i_Rst;
  logic       i_BitEn;
  logic       i_Rx;
  logic [1:0] i_Parity;
  logic [7:0] o_Data;
  logic       o_Valid;
  logic       o_ParityErr;
  logic       o_FrameErr;
  logic       o_Busy;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t sb_q[$];
  int   vtimes[$];
  int   checks = 0;
  int   errors = 0;
  int   vcount = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;

  rxparity dut (
    .i_Pclk      (clk),
    .i_Rst       (i_Rst),
    .i_BitEn     (i_BitEn),
    .i_Rx        (i_Rx),
    .i_Parity    (i_Parity),
    .o_Data      (o_Data),
    .o_Valid     (o_Valid),
    .o_ParityErr (o_ParityErr),
    .o_FrameErr  (o_FrameErr),
    .o_Busy      (o_Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_perr(input logic [7:0] d, input logic p,
                                    input logic [1:0] m);
    logic tot;
    tot = ^d ^ p;
    if (m == 2'b01) return tot;
    if (m == 2'b10) return ~tot;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (!i_Rst && o_Valid) begin
      exp_t e;
      vcount++;
      vtimes.push_back(cyc);
      if (prev_valid) check("vwidth", 1, 0);
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("data", o_Data, e.data);
        check("perr", o_ParityErr, e.perr);
        check("ferr", o_FrameErr, e.ferr);
      end
    end
    prev_valid = o_Valid;
  end

  // Non-strobed cycles drive the inverted bit so ignored edges are exercised.
  task automatic send_bit(input logic b, input int stride);
    for (int i = 0; i < stride; i++) begin
      i_BitEn = (i == stride - 1);
      i_Rx    = (i == stride - 1) ? b : ~b;
      @(posedge clk);
      #1;
    end
    i_BitEn = 1'b0;
    i_Rx    = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic stp, input int stride,
                            input logic [1:0] m, input logic tog);
    exp_t e;
    e.data = d;
    e.perr = exp_perr(d, p, m);
    e.ferr = ~stp;
    sb_q.push_back(e);
    i_Parity = m;
    send_bit(1'b0, stride);
    for (int i = 0; i < 8; i++) begin
      if (tog && i == 3) i_Parity = ~m;
      send_bit(d[i], stride);
    end
    send_bit(p, stride);
    send_bit(stp, stride);
    i_Parity = m;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1, 1);
  endtask

  initial begin
    int vc0;
    i_Rst    = 1'b0;
    i_BitEn  = 1'b0;
    i_Rx     = 1'b1;
    i_Parity = 2'b00;
    #1 i_Rst = 1'b1;
    #2;
    check("rst_data", o_Data, 8'h00);
    check("rst_valid", o_Valid, 0);
    check("rst_perr", o_ParityErr, 0);
    check("rst_ferr", o_FrameErr, 0);
    check("rst_busy", o_Busy, 0);
    repeat (2) @(posedge clk);
    #1 i_Rst = 1'b0;
    idle(2);

    send_frame(8'hA5, 1'b0, 1'b1, 1, 2'b01, 1'b0);
    check("lat_valid", o_Valid, 1);
    check("lat_data", o_Data, 8'hA5);
    @(posedge clk);
    #1;
    check("pulse_low", o_Valid, 0);
    check("hold_data", o_Data, 8'hA5);
    idle(2);

    send_frame(8'h01, 1'b1, 1'b1, 1, 2'b10, 1'b0);
    idle(2);
    check("hold_perr", o_ParityErr, 1);
    send_frame(8'h3C, 1'b1, 1'b0, 1, 2'b00, 1'b0);
    idle(2);

    vc0 = vcount;
    send_frame(8'hFF, 1'b0, 1'b1, 4, 2'b01, 1'b1);
    idle(3);
    check("stride_vcount", vcount - vc0, 1);

    vtimes.delete();
    send_frame(8'h12, 1'b0, 1'b1, 1, 2'b01, 1'b0);
    send_frame(8'h34, 1'b1, 1'b1, 1, 2'b01, 1'b0);
    idle(2);
    check("b2b_count", vtimes.size(), 2);
    if (vtimes.size() == 2) check("b2b_gap", vtimes[1] - vtimes[0], 11);

    send_frame(8'h5A, 1'b0, 1'b1, 1, 2'b01, 1'b0);
    idle(2);
    check("sb_empty", sb_q.size(), 0);

    vc0 = vcount;
    i_Parity = 2'b01;
    send_bit(1'b0, 1);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1);
    check("mid_busy", o_Busy, 1);
    i_Rst = 1'b1;
    #2;
    check("async_busy", o_Busy, 0);
    check("async_data", o_Data, 8'h00);
    @(posedge clk);
    #1 i_Rst = 1'b0;
    idle(3);
    check("abort_vcount", vcount - vc0, 0);
    check("abort_busy", o_Busy, 0);
    check("abort_data", o_Data, 8'h00);
    check("abort_valid", o_Valid, 0);
    check("abort_perr", o_ParityErr, 0);
    check("abort_ferr", o_FrameErr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
